// File: rtl/ycbcr_blk_buf_if.sv
// Pixel stream bundle around the raster-to-block reorder buffer.
// Inputs to the buffer: y/cb/cr + vld_i (raster order, no backpressure), rdy_i.
// Outputs from the buffer: y_o/cb_o/cr_o + vld_o (block order), blk_idx_o,
// blk_last_o, ovf_o.
// master: upstream/downstream environment side; slave: the buffer itself.
interface ycbcr_blk_buf_if #(
    parameter int unsigned DATA_W = 20
);
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] cb;
    logic [DATA_W-1:0] cr;
    logic              vld_i;
    logic [DATA_W-1:0] y_o;
    logic [DATA_W-1:0] cb_o;
    logic [DATA_W-1:0] cr_o;
    logic              vld_o;
    logic              rdy_i;
    logic [5:0]        blk_idx_o;
    logic              blk_last_o;
    logic              ovf_o;

    modport master (
        output y, cb, cr, vld_i, rdy_i,
        input  y_o, cb_o, cr_o, vld_o, blk_idx_o, blk_last_o, ovf_o
    );

    modport slave (
        input  y, cb, cr, vld_i, rdy_i,
        output y_o, cb_o, cr_o, vld_o, blk_idx_o, blk_last_o, ovf_o
    );
endinterface

// File: rtl/ycbcr_blk_buf.sv
// Raster-to-8x8-block reorder buffer for Y/Cb/Cr samples feeding the DCT.
// Ping-pong storage: each bank holds one 8-row stripe of all three components.
// Ports:
//   clk   - system clock, rising edge
//   rstn  - asynchronous active-low reset, discards all buffered data
//   bus   - slave side of ycbcr_blk_buf_if: raster pixels in (vld_i, no ready),
//           block-ordered samples out (vld_o/rdy_i), block index/last, sticky ovf
module ycbcr_blk_buf #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned IMG_W  = 64
) (
    input  logic             clk,
    input  logic             rstn,
    ycbcr_blk_buf_if.slave   bus
);
    localparam int unsigned WORD_W = 3 * DATA_W;
    localparam int unsigned STRIPE = 8 * IMG_W;
    localparam int unsigned DEPTH  = 2 * STRIPE;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(STRIPE);
    localparam int unsigned COL_W  = $clog2(IMG_W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    logic [WORD_W-1:0] mem [DEPTH];

    // write side state
    logic [COL_W-1:0]  wr_col;
    logic [2:0]        wr_row;
    logic              wr_bank;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              ovf;
    logic              wr_en_c;
    logic              wr_end_c;
    logic [ADDR_W-1:0] wr_addr_c;

    // read issue side
    state_t            state;
    state_t            state_nxt;
    logic              rd_bank;
    logic              rd_bank_nxt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  rd_cnt_nxt;
    logic              issue_c;
    logic [ADDR_W-1:0] rd_addr_c;

    // memory-read stage
    logic              p_vld;
    logic [5:0]        p_idx;
    logic              p_end;
    logic              p_bank;
    logic [WORD_W-1:0] q;

    // output register
    logic              vld_q;
    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] cb_q;
    logic [DATA_W-1:0] cr_q;
    logic [5:0]        idx_q;
    logic              last_q;
    logic              end_q;
    logic              bank_q;

    logic              adv_c;
    logic              s1_acc_c;
    logic              xfer_end_c;

    assign adv_c      = !vld_q || bus.rdy_i;
    assign s1_acc_c   = !p_vld || adv_c;
    assign xfer_end_c = vld_q && bus.rdy_i && end_q;

    // a write is dropped while its bank is full, including the cycle it frees
    assign wr_en_c   = bus.vld_i && !full[wr_bank];
    assign wr_end_c  = wr_en_c && (wr_row == 3'd7) && (wr_col == COL_W'(IMG_W - 1));
    assign wr_addr_c = ADDR_W'(wr_bank) * ADDR_W'(STRIPE)
                     + ADDR_W'(wr_row) * ADDR_W'(IMG_W)
                     + ADDR_W'(wr_col);

    // rd_cnt = {block, row, col}: col in [2:0], row in [5:3], block above
    assign rd_addr_c = ADDR_W'(rd_bank) * ADDR_W'(STRIPE)
                     + ADDR_W'(rd_cnt[5:3]) * ADDR_W'(IMG_W)
                     + ADDR_W'(rd_cnt >> 6) * ADDR_W'(8)
                     + ADDR_W'(rd_cnt[2:0]);

    // bank full flags: set by the completing write, cleared by the last transfer
    always_comb begin
        full_nxt = full;
        if (xfer_end_c) full_nxt[bank_q] = 1'b0;
        if (wr_end_c)   full_nxt[wr_bank] = 1'b1;
    end

    // write counters, bank toggle and sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_col  <= '0;
            wr_row  <= '0;
            wr_bank <= 1'b0;
            full    <= '0;
            ovf     <= 1'b0;
        end else begin
            full <= full_nxt;
            if (bus.vld_i && full[wr_bank]) ovf <= 1'b1;
            if (wr_en_c) begin
                if (wr_col == COL_W'(IMG_W - 1)) begin
                    wr_col <= '0;
                    if (wr_row == 3'd7) begin
                        wr_row  <= '0;
                        wr_bank <= ~wr_bank;
                    end else begin
                        wr_row <= wr_row + 3'd1;
                    end
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end
        end
    end

    // read FSM: IDLE waits for the read bank to fill, RUN streams it.
    // Leaving RUN on the last issued address and re-checking in IDLE the same
    // cycle lets a full second bank start without a bubble.
    always_comb begin
        state_nxt   = state;
        rd_bank_nxt = rd_bank;
        rd_cnt_nxt  = rd_cnt;
        issue_c     = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank] && s1_acc_c) begin
                    issue_c   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (s1_acc_c) issue_c = 1'b1;
            end
        endcase
        if (issue_c) begin
            if (rd_cnt == CNT_W'(STRIPE - 1)) begin
                rd_cnt_nxt  = '0;
                rd_bank_nxt = ~rd_bank;
                state_nxt   = IDLE;
            end else begin
                rd_cnt_nxt = rd_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            rd_bank <= rd_bank_nxt;
            rd_cnt  <= rd_cnt_nxt;
        end
    end

    // storage with registered read; q only advances when the read stage accepts
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_addr_c] <= {bus.y, bus.cb, bus.cr};
        if (issue_c) q <= mem[rd_addr_c];
    end

    // read-stage tags travelling alongside q
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_vld  <= 1'b0;
            p_idx  <= '0;
            p_end  <= 1'b0;
            p_bank <= 1'b0;
        end else if (s1_acc_c) begin
            p_vld <= issue_c;
            if (issue_c) begin
                p_idx  <= rd_cnt[5:0];
                p_end  <= (rd_cnt == CNT_W'(STRIPE - 1));
                p_bank <= rd_bank;
            end
        end
    end

    // output register, held while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            y_q    <= '0;
            cb_q   <= '0;
            cr_q   <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            end_q  <= 1'b0;
            bank_q <= 1'b0;
        end else if (adv_c) begin
            vld_q <= p_vld;
            if (p_vld) begin
                y_q    <= q[WORD_W-1 -: DATA_W];
                cb_q   <= q[2*DATA_W-1 -: DATA_W];
                cr_q   <= q[DATA_W-1:0];
                idx_q  <= p_idx;
                last_q <= (p_idx == 6'd63);
                end_q  <= p_end;
                bank_q <= p_bank;
            end
        end
    end

    assign bus.y_o        = y_q;
    assign bus.cb_o       = cb_q;
    assign bus.cr_o       = cr_q;
    assign bus.vld_o      = vld_q;
    assign bus.blk_idx_o  = idx_q;
    assign bus.blk_last_o = last_q;
    assign bus.ovf_o      = ovf;
endmodule

// File: tb/tb_ycbcr_blk_buf.sv
// Bench for ycbcr_blk_buf: scenario table plus hand-written overflow/reset
// sequences, all checked against a stripe-level reference model.
module tb_ycbcr_blk_buf;
    localparam int unsigned DATA_W = 20;
    localparam int unsigned IMG_W  = 16;
    localparam int unsigned NPIX   = 8 * IMG_W;
    localparam int unsigned NBLK   = IMG_W / 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ycbcr_blk_buf_if #(.DATA_W(DATA_W)) bus();

    ycbcr_blk_buf #(.DATA_W(DATA_W), .IMG_W(IMG_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] cb;
        logic [DATA_W-1:0] cr;
    } pix_t;

    typedef struct {
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] cb;
        logic [DATA_W-1:0] cr;
        logic [5:0]        idx;
        logic              last;
        bit                stripe_end;
    } smp_t;

    // scenario record: stimulus modes and the expected observable results
    typedef struct {
        string name;
        int    npix;      // number of valid pixels to feed
        int    vld_mode;  // 0 continuous, 1 alternate cycles, 2 random (random data)
        int    rdy_mode;  // 0 always 1, 1 pattern 1,0,0,1, 2 random
        int    exp_xfer;  // expected transfers, -1 = model only
        int    exp_lat;   // cycles from last write edge to vld_o, -1 = skip
        int    exp_span;  // last transfer cycle - first transfer cycle, -1 = skip
        int    exp_ovf;   // final ovf_o, -1 = skip
    } vec_t;

    pix_t stripe_q[$];
    smp_t exp_q[$];
    int   pending;
    bit   ovf_exp;
    int   cyc;
    int   n_xfer, first_obs, first_xfer, last_xfer, done_edge;
    int   n_vec, n_err;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        stripe_q.delete();
        exp_q.delete();
        pending    = 0;
        ovf_exp    = 1'b0;
        n_xfer     = 0;
        first_obs  = -1;
        first_xfer = -1;
        last_xfer  = -1;
        done_edge  = -1;
    endtask

    // a complete stripe becomes its samples in block-row-major, 8x8 block order
    task automatic complete_stripe();
        smp_t s;
        for (int b = 0; b < int'(NBLK); b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    s.y          = stripe_q[r * IMG_W + b * 8 + c].y;
                    s.cb         = stripe_q[r * IMG_W + b * 8 + c].cb;
                    s.cr         = stripe_q[r * IMG_W + b * 8 + c].cr;
                    s.idx        = 6'(r * 8 + c);
                    s.last       = (r == 7) && (c == 7);
                    s.stripe_end = (b == int'(NBLK) - 1) && (r == 7) && (c == 7);
                    exp_q.push_back(s);
                end
        stripe_q.delete();
        pending++;
        if (done_edge < 0) done_edge = cyc;
    endtask

    // one clock: check outputs of the previous edge, drive inputs, advance model
    task automatic cycle(input bit vld, input logic [DATA_W-1:0] py, input logic [DATA_W-1:0] pcb,
                         input logic [DATA_W-1:0] pcr, input bit rdy);
        smp_t e;
        pix_t p;
        bit   xfer;
        bit   drop;
        @(negedge clk);
        chk("ovf_o", bus.ovf_o, ovf_exp);
        if (bus.vld_o) begin
            if (first_obs < 0) first_obs = cyc;
            if (exp_q.size() == 0) begin
                chk("vld_o_unexpected", bus.vld_o, 0);
            end else begin
                e = exp_q[0];
                chk("y_o", bus.y_o, e.y);
                chk("cb_o", bus.cb_o, e.cb);
                chk("cr_o", bus.cr_o, e.cr);
                chk("blk_idx_o", bus.blk_idx_o, e.idx);
                chk("blk_last_o", bus.blk_last_o, e.last);
            end
        end
        xfer = bus.vld_o && rdy;
        bus.vld_i = vld;
        bus.y     = py;
        bus.cb    = pcb;
        bus.cr    = pcr;
        bus.rdy_i = rdy;
        // both banks hold unread stripes exactly when two are pending
        drop = vld && (pending == 2);
        if (drop) ovf_exp = 1'b1;
        if (xfer && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_xfer++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            if (e.stripe_end) pending--;
        end
        if (vld && !drop) begin
            p.y  = py;
            p.cb = pcb;
            p.cr = pcr;
            stripe_q.push_back(p);
            if (stripe_q.size() == NPIX) complete_stripe();
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.vld_i = 1'b0;
        bus.rdy_i = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_y_o", bus.y_o, 0);
        chk("rst_cb_o", bus.cb_o, 0);
        chk("rst_cr_o", bus.cr_o, 0);
        chk("rst_vld_o", bus.vld_o, 0);
        chk("rst_blk_idx_o", bus.blk_idx_o, 0);
        chk("rst_blk_last_o", bus.blk_last_o, 0);
        chk("rst_ovf_o", bus.ovf_o, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    function automatic bit rdy_of(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return ($urandom % 4) != 0;
    endfunction

    task automatic drain(input int mode, input int k0);
        int k;
        int guard;
        k = k0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 4000) begin
            cycle(1'b0, '0, '0, '0, rdy_of(mode, k));
            k++;
            guard++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, '0, rdy_of(mode, k));
            k++;
        end
    endtask

    task automatic feed_index(input int n, input bit rdy);
        for (int p = 0; p < n; p++)
            cycle(1'b1, DATA_W'(p), DATA_W'(p + 1000), DATA_W'(p + 2000), rdy);
    endtask

    task automatic run_vec(input vec_t v);
        int fed;
        int k;
        bit vld;
        logic [DATA_W-1:0] py, pcb, pcr;
        do_reset();
        fed = 0;
        k = 0;
        while (fed < v.npix) begin
            if (v.vld_mode == 0)      vld = 1'b1;
            else if (v.vld_mode == 1) vld = (k % 2 == 0);
            else                      vld = ($urandom % 4) != 0;
            if (v.vld_mode == 2) begin
                py  = DATA_W'($urandom);
                pcb = DATA_W'($urandom);
                pcr = DATA_W'($urandom);
            end else begin
                py  = DATA_W'(fed);
                pcb = DATA_W'(fed + 1000);
                pcr = DATA_W'(fed + 2000);
            end
            cycle(vld, py, pcb, pcr, rdy_of(v.rdy_mode, k));
            if (vld) fed++;
            k++;
        end
        drain(v.rdy_mode, k);
        if (v.exp_xfer >= 0) chk({v.name, "_n_xfer"}, n_xfer, v.exp_xfer);
        if (v.exp_lat >= 0)  chk({v.name, "_latency"}, (first_obs - 1) - done_edge, v.exp_lat);
        if (v.exp_span >= 0) chk({v.name, "_span"}, last_xfer - first_xfer, v.exp_span);
        if (v.exp_ovf >= 0)  chk({v.name, "_ovf_final"}, bus.ovf_o, v.exp_ovf);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        bus.vld_i = 1'b0;
        bus.rdy_i = 1'b0;
        bus.y  = '0;
        bus.cb = '0;
        bus.cr = '0;
        model_reset();

        tbl[0] = '{"single",   128, 0, 0, 128, 2, 127, 0};
        tbl[1] = '{"b2b",      256, 0, 0, 256, 2, 255, 0};
        tbl[2] = '{"gaps",     128, 1, 0, 128, 2, 127, 0};
        tbl[3] = '{"backpres", 128, 0, 1, 128, -1, -1, 0};
        tbl[4] = '{"random",   700, 2, 2, -1, -1, -1, -1};

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // overflow: no ready for two full stripes plus one pixel
        do_reset();
        feed_index(257, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0);
        chk("ovf_after_257", bus.ovf_o, 1);
        drain(0, 0);
        chk("ovf_n_xfer", n_xfer, 256);
        chk("ovf_sticky", bus.ovf_o, 1);

        // reset mid-stripe, then a fresh single stripe
        do_reset();
        feed_index(50, 1'b1);
        run_vec(tbl[0]);

        // reset mid-readout, then a fresh single stripe
        do_reset();
        feed_index(128, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, '0, 1'b1);
        run_vec(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
